instruction_fetch: RTL and testbench

- Multi-cycle fetch stage. It sits directly upstream of the program counter and decode.
- On a fetch request from the control FSM, it latches the current pc, issues a word read to instruction memory through a valid/ready handshake, and captures the returned word in the instruction register (IR).
- It presents the decoded opcode, func3, func7 and register indices to the branch/PC logic and the register file, and holds them until they are acknowledged.

---
 rtl/rv_pkg.sv | 24 ++
 rtl/instruction_fetch.sv | 124 ++++++++++++
 tb/tb_instruction_fetch.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I definitions: base opcodes, the reset/bubble instruction and
// the fetch-stage state type.
package rv_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // addi x0,x0,0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_REQ   = 2'd1,
        FS_VALID = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch.sv
// Multi-cycle instruction fetch: latches pc, reads one word over a valid/ready
// handshake into the IR and holds the decoded fields until acknowledged.
module instruction_fetch
    import rv_pkg::*;
#(
    parameter int          XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = rv_pkg::NOP_INSTR,
    parameter int          MAX_WAIT  = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc,
    input  logic            fetch_start,
    input  logic            instr_ack,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_ready,
    input  logic [31:0]     mem_rdata,
    output logic [31:0]     instr,
    output logic [6:0]      opcode,
    output logic [4:0]      rd,
    output logic [2:0]      func3,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [6:0]      func7,
    output logic            instr_valid,
    output logic            busy,
    output logic            misaligned_fault,
    output logic            timeout_fault
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    fetch_state_t    state_q, state_d;
    logic [31:0]     ir_q, ir_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            mis_q, mis_d;
    logic            tout_q, tout_d;
    logic            pc_aligned;

    assign pc_aligned = (pc[1:0] == 2'b00);

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        mis_d   = 1'b0;
        tout_d  = 1'b0;
        case (state_q)
            FS_IDLE: begin
                if (fetch_start) begin
                    if (pc_aligned) begin
                        addr_d  = pc;
                        cnt_d   = '0;
                        state_d = FS_REQ;
                    end else begin
                        mis_d = 1'b1;
                    end
                end
            end
            FS_REQ: begin
                // A response on the expiry cycle still completes the fetch.
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    state_d = FS_VALID;
                end else if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
                    tout_d  = 1'b1;
                    state_d = FS_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FS_VALID: begin
                if (instr_ack) begin
                    if (fetch_start && pc_aligned) begin
                        addr_d  = pc;
                        cnt_d   = '0;
                        state_d = FS_REQ;
                    end else begin
                        mis_d   = fetch_start;
                        state_d = FS_IDLE;
                    end
                end
            end
            default: state_d = FS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FS_IDLE;
            ir_q    <= NOP_INSTR;
            addr_q  <= '0;
            cnt_q   <= '0;
            mis_q   <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
            tout_q  <= tout_d;
        end
    end

    assign mem_req          = (state_q == FS_REQ);
    assign instr_valid      = (state_q == FS_VALID);
    assign busy             = (state_q == FS_REQ) || (state_q == FS_VALID);
    assign mem_addr         = addr_q;
    assign misaligned_fault = mis_q;
    assign timeout_fault    = tout_q;

    assign instr  = ir_q;
    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign func3  = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign func7  = ir_q[31:25];

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch (MAX_WAIT=4); returned words are
// scoreboarded when mem_ready is driven and compared when instr_valid rises.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        fetch_start;
    logic        instr_ack;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  func3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  func7;
    logic        instr_valid;
    logic        busy;
    logic        misaligned_fault;
    logic        timeout_fault;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [31:0] sb[$];

    instruction_fetch #(.XLEN(32), .NOP_INSTR(32'h0000_0013), .MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset), .pc(pc), .fetch_start(fetch_start),
        .instr_ack(instr_ack), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .instr(instr),
        .opcode(opcode), .rd(rd), .func3(func3), .rs1(rs1), .rs2(rs2),
        .func7(func7), .instr_valid(instr_valid), .busy(busy),
        .misaligned_fault(misaligned_fault), .timeout_fault(timeout_fault)
    );

    always #5 clk = ~clk;

    // Advance one cycle; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sb_check();
        if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL instr_sb observed=%h expected=<empty scoreboard>", instr);
        end else begin
            chk("instr_sb", instr, sb.pop_front());
        end
    endtask

    task automatic respond(input logic [31:0] word);
        mem_ready = 1'b1;
        mem_rdata = word;
        sb.push_back(word);
    endtask

    initial begin
        reset = 1'b1; pc = '0; fetch_start = 1'b0; instr_ack = 1'b0;
        mem_ready = 1'b0; mem_rdata = '0;
        step(); step();
        reset = 1'b0;
        step();
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_opcode", 32'(opcode), 32'h13);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_faults", {30'd0, misaligned_fault, timeout_fault}, 32'd0);

        // Basic fetch with response on cycle 3
        pc = 32'h0000_0100; fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        pc = 32'h0000_0200;
        chk("bf_req_c1", 32'(mem_req), 32'd1);
        chk("bf_addr_c1", mem_addr, 32'h100);
        step();
        chk("bf_addr_c2", mem_addr, 32'h100);
        step();
        chk("bf_addr_c3", mem_addr, 32'h100);
        chk("bf_valid_c3", 32'(instr_valid), 32'd0);
        respond(32'h00B5_0463);
        step();
        mem_ready = 1'b0;
        chk("bf_valid_c4", 32'(instr_valid), 32'd1);
        chk("bf_req_c4", 32'(mem_req), 32'd0);
        sb_check();
        chk("bf_opcode", 32'(opcode), 32'b1100011);
        chk("bf_func3", 32'(func3), 32'd0);
        chk("bf_rs1", 32'(rs1), 32'd10);
        chk("bf_rs2", 32'(rs2), 32'd11);
        chk("bf_rd", 32'(rd), 32'd8);
        chk("bf_func7", 32'(func7), 32'd0);
        step();
        chk("bf_hold_valid", 32'(instr_valid), 32'd1);
        chk("bf_hold_instr", instr, 32'h00B5_0463);

        // Back-to-back ack + fetch
        pc = 32'h0000_0104; instr_ack = 1'b1; fetch_start = 1'b1;
        step();
        instr_ack = 1'b0; fetch_start = 1'b0;
        chk("b2b_req", 32'(mem_req), 32'd1);
        chk("b2b_addr", mem_addr, 32'h104);
        chk("b2b_valid", 32'(instr_valid), 32'd0);
        chk("b2b_busy", 32'(busy), 32'd1);
        respond(32'h0031_00B3);
        step();
        mem_ready = 1'b0;
        chk("b2b_valid2", 32'(instr_valid), 32'd1);
        sb_check();
        chk("b2b_rd", 32'(rd), 32'd1);
        chk("b2b_rs1", 32'(rs1), 32'd2);
        chk("b2b_rs2", 32'(rs2), 32'd3);
        instr_ack = 1'b1;
        step();
        instr_ack = 1'b0;
        chk("ack_valid", 32'(instr_valid), 32'd0);
        chk("ack_busy", 32'(busy), 32'd0);

        // Misaligned start from IDLE
        pc = 32'h0000_0102; fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        chk("mis_pulse", 32'(misaligned_fault), 32'd1);
        chk("mis_req", 32'(mem_req), 32'd0);
        chk("mis_instr", instr, 32'h0031_00B3);
        chk("mis_addr", mem_addr, 32'h104);
        step();
        chk("mis_pulse_end", 32'(misaligned_fault), 32'd0);
        chk("mis_req2", 32'(mem_req), 32'd0);

        // Timeout after 4 REQ cycles
        pc = 32'h0000_0200; fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("to_req_c%0d", i + 1), 32'(mem_req), 32'd1);
            chk($sformatf("to_flag_c%0d", i + 1), 32'(timeout_fault), 32'd0);
            step();
        end
        chk("to_pulse", 32'(timeout_fault), 32'd1);
        chk("to_idle_req", 32'(mem_req), 32'd0);
        chk("to_idle_busy", 32'(busy), 32'd0);
        chk("to_instr", instr, 32'h0031_00B3);
        step();
        chk("to_pulse_end", 32'(timeout_fault), 32'd0);

        // Response on the expiry cycle wins
        pc = 32'h0000_0300; fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        step(); step(); step();
        chk("race_req_c4", 32'(mem_req), 32'd1);
        respond(32'hFFF0_0093);
        step();
        mem_ready = 1'b0;
        chk("race_valid", 32'(instr_valid), 32'd1);
        chk("race_timeout", 32'(timeout_fault), 32'd0);
        sb_check();

        // Ack with misaligned fetch from VALID
        pc = 32'h0000_0301; instr_ack = 1'b1; fetch_start = 1'b1;
        step();
        instr_ack = 1'b0; fetch_start = 1'b0;
        chk("vmis_pulse", 32'(misaligned_fault), 32'd1);
        chk("vmis_valid", 32'(instr_valid), 32'd0);
        chk("vmis_req", 32'(mem_req), 32'd0);

        // Stray response in IDLE
        mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        step();
        mem_ready = 1'b0;
        chk("stray_instr", instr, 32'hFFF0_0093);
        chk("stray_valid", 32'(instr_valid), 32'd0);

        // Reset mid-REQ, then a late response
        pc = 32'h0000_0400; fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        chk("rreq_req", 32'(mem_req), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rreq_mem_req", 32'(mem_req), 32'd0);
        chk("rreq_instr", instr, 32'h0000_0013);
        chk("rreq_opcode", 32'(opcode), 32'h13);
        chk("rreq_valid", 32'(instr_valid), 32'd0);
        chk("rreq_addr", mem_addr, 32'd0);
        mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
        step();
        mem_ready = 1'b0;
        chk("late_instr", instr, 32'h0000_0013);
        chk("late_valid", 32'(instr_valid), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
